router_port_ingress: RTL

//  - Router local-port ingress: receive end of the credit-based flit link driven by the ddma send path.
//  - Buffers incoming flits in a FIFO and frames them into packets: header flit, size flit, SIZE payload flits.
//  - Presents framed flits to the router crossbar/arbiter with a valid/ready handshake and sof/eof markers.

---
 rtl/router_port_ingress_pkg.sv | 18 +
 rtl/router_port_ingress_if.sv | 14 +
 rtl/router_port_ingress_fifo.sv | 52 +++++
 rtl/router_port_ingress.sv | 99 +++++++++
 4 files changed

// File: rtl/router_port_ingress_pkg.sv
// Shared types for the router local-port ingress block.
// The flit width and buffer depth defaults live here.
// The framing FSM state encoding also lives here.
package router_pkg;

    localparam int DEF_FLIT_WIDTH   = 32;
    localparam int DEF_BUFFER_DEPTH = 4;
    localparam int SIZE_FIELD_W     = 16;

    typedef logic [DEF_FLIT_WIDTH-1:0] flit_t;

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_SIZE    = 2'd1,
        S_PAYLOAD = 2'd2
    } ingress_state_e;

endpackage

// File: rtl/router_port_ingress_if.sv
// Framed flit stream from the ingress port to the crossbar/arbiter.
// The master drives valid/data/sof/eof and the slave returns ready.
interface router_port_ingress_if #(
    parameter int FLIT_WIDTH = 32
) ();
    logic                  out_valid;
    logic [FLIT_WIDTH-1:0] out_data;
    logic                  out_sof;
    logic                  out_eof;
    logic                  out_ready;

    modport master (output out_valid, output out_data, output out_sof, output out_eof, input out_ready);
    modport slave  (input  out_valid, input  out_data, input  out_sof, input  out_eof, output out_ready);
endinterface

// File: rtl/router_port_ingress_fifo.sv
// Circular flit buffer with a fall-through head.
// The push and pop requests are qualified internally by full and empty.
// rdata reads as zero while the buffer is empty, so the head never shows stale data.
module ingress_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; the pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; it has no reset because the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/router_port_ingress.sv
// Router local-port ingress: credit-based receive FIFO plus packet framing.
// A packet is one header flit, one size flit, and then SIZE payload flits.
// Optional stats counters are built when ROUTER_INGRESS_STATS_EN is defined.
module router_port_ingress
    import router_pkg::*;
#(
    parameter int FLIT_WIDTH   = DEF_FLIT_WIDTH,
    parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rx_in,
    input  logic [FLIT_WIDTH-1:0]    data_in,
    output logic                     credit_out,
    router_port_ingress_if.master    out_if,
    output logic [15:0]              stat_pkts,
    output logic [15:0]              stat_drops
);
    logic                    fifo_full, fifo_empty;
    logic [FLIT_WIDTH-1:0]   head;
    logic                    pop_fire;
    ingress_state_e          state;
    logic [SIZE_FIELD_W-1:0] rem;
    logic [SIZE_FIELD_W-1:0] size_fld;

    ingress_fifo #(.W(FLIT_WIDTH), .DEPTH(BUFFER_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_in),
        .wdata (data_in),
        .pop   (out_if.out_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Credit follows the registered count only, so a same-cycle pop does not reopen it early.
    assign credit_out       = !fifo_full;
    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = head;
    assign pop_fire         = out_if.out_valid && out_if.out_ready;
    assign size_fld         = head[SIZE_FIELD_W-1:0];

    // Frame markers are decoded from the state and the remaining count, and are gated by valid.
    always_comb begin
        out_if.out_sof = 1'b0;
        out_if.out_eof = 1'b0;
        if (out_if.out_valid) begin
            case (state)
                S_HEADER:  out_if.out_sof = 1'b1;
                S_SIZE:    out_if.out_eof = (size_fld == '0);
                S_PAYLOAD: out_if.out_eof = (rem == SIZE_FIELD_W'(1));
                default:   out_if.out_sof = 1'b0;
            endcase
        end
    end

    // Framing FSM; it advances only on an accepted flit and holds across an empty FIFO.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_HEADER;
            rem   <= '0;
        end else if (pop_fire) begin
            case (state)
                S_HEADER: state <= S_SIZE;
                S_SIZE: begin
                    rem   <= size_fld;
                    state <= (size_fld == '0) ? S_HEADER : S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    rem <= rem - 1'b1;
                    if (rem == SIZE_FIELD_W'(1)) state <= S_HEADER;
                end
                default: state <= S_HEADER;
            endcase
        end
    end

`ifdef ROUTER_INGRESS_STATS_EN
    logic [15:0] pkts_q, drops_q;

    // Saturating counters: one counts completed packets and the other counts flits refused while full.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pkts_q  <= '0;
            drops_q <= '0;
        end else begin
            if (pop_fire && out_if.out_eof && pkts_q != 16'hFFFF) pkts_q <= pkts_q + 1'b1;
            if (rx_in && fifo_full && drops_q != 16'hFFFF)        drops_q <= drops_q + 1'b1;
        end
    end

    assign stat_pkts  = pkts_q;
    assign stat_drops = drops_q;
`else
    assign stat_pkts  = '0;
    assign stat_drops = '0;
`endif
endmodule
